// File: rtl/fetch_ctrl.sv
// Instruction fetch stage: steers the PC counter (hold/load/restart) and queues
// {addr, data} pairs from the synchronous RAM into a 2-entry valid/ready queue.
module fetch_ctrl #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic [DW-1:0] mem_rdata,
    input  logic          branch_req,
    input  logic [AW-1:0] branch_target,
    input  logic          restart,
    output logic          model_sel,
    output logic [AW-1:0] load_value,
    output logic          pc_recount,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_addr,
    output logic          instr_valid,
    input  logic          instr_ready
);

    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_data [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          req_valid_q;
    logic [AW-1:0] req_addr_q;
    logic          pop;
    logic          accept;
    logic          flush;

    assign flush      = restart | branch_req;
    assign instr      = q_data[rd_ptr];
    assign instr_addr = q_addr[rd_ptr];

    always_comb begin
        model_sel   = 1'b0;
        load_value  = pc_in;
        pc_recount  = 1'b0;
        instr_valid = 1'b0;
        pop         = 1'b0;
        accept      = 1'b0;
        count_next  = count;
        if (!reset) begin
            if (restart) begin
                pc_recount = 1'b1;
            end else if (branch_req) begin
                model_sel  = 1'b1;
                load_value = branch_target;
            end else begin
                instr_valid = (count != 2'd0);
                pop         = instr_valid & instr_ready;
                count_next  = count + {1'b0, req_valid_q} - {1'b0, pop};
                // Only take a new address if its data will have a free slot;
                // otherwise hold the PC so the same address is re-issued.
                accept      = (count_next <= 2'd1);
                model_sel   = ~accept;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else if (flush) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            if (req_valid_q) begin
                q_addr[wr_ptr] <= req_addr_q;
                q_data[wr_ptr] <= mem_rdata;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count       <= count_next;
            req_valid_q <= accept;
            if (accept) begin
                req_addr_q <= pc_in;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC counter and a RAM holding
// mem[a] = a ^ 8'h5A, and checks the instruction stream cycle by cycle.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc;
    logic [7:0] mem_rdata = 8'h00;
    logic       branch_req = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       restart = 1'b0;
    logic       model_sel;
    logic [7:0] load_value;
    logic       pc_recount;
    logic [7:0] instr;
    logic [7:0] instr_addr;
    logic       instr_valid;
    logic       instr_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    fetch_ctrl #(.DW(8), .AW(8)) dut (
        .clk(clk), .reset(reset), .pc_in(pc), .mem_rdata(mem_rdata),
        .branch_req(branch_req), .branch_target(branch_target), .restart(restart),
        .model_sel(model_sel), .load_value(load_value), .pc_recount(pc_recount),
        .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           pc <= 8'h00;
        else if (pc_recount) pc <= 8'h00;
        else if (model_sel)  pc <= load_value;
        else                 pc <= pc + 8'd1;
    end

    always @(posedge clk) mem_rdata <= pc ^ 8'h5A;

    // The queue must never claim more than two entries.
    always @(negedge clk) begin
        if (!reset && dut.count > 2'd2) begin
            miscompares++;
            $display("FAIL occupancy count=%0d limit=2", dut.count);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with reset just released: cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        branch_req = 1'b0;
        restart = 1'b0;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        restart = 1'b1;
        branch_req = 1'b1;
        branch_target = 8'h33;
        @(negedge clk);
        #2;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid got %b want 0", instr_valid);
        end
        vectors++;
        if (model_sel !== 1'b0) begin
            miscompares++; $display("FAIL reset_model_sel got %b want 0", model_sel);
        end
        vectors++;
        if (pc_recount !== 1'b0) begin
            miscompares++; $display("FAIL reset_pc_recount got %b want 0", pc_recount);
        end
        vectors++;
        if (load_value !== 8'h00) begin
            miscompares++; $display("FAIL reset_load_value got %h want 00", load_value);
        end
        vectors++;
        if (instr !== 8'h00 || instr_addr !== 8'h00) begin
            miscompares++; $display("FAIL reset_head got %h/%h want 00/00", instr_addr, instr);
        end
        restart = 1'b0;
        branch_req = 1'b0;
        branch_target = 8'h00;
    endtask

    task automatic test_stream();
        logic [7:0] ea;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            #2;
            ea = 8'(c - 2);
            vectors++;
            if (instr_valid !== (c >= 2)) begin
                miscompares++; $display("FAIL stream_valid c=%0d got %b want %b", c, instr_valid, c >= 2);
            end else if (c >= 2 && (instr_addr !== ea || instr !== (ea ^ 8'h5A))) begin
                miscompares++;
                $display("FAIL stream_pair c=%0d got %h/%h want %h/%h", c, instr_addr, instr, ea, ea ^ 8'h5A);
            end
            vectors++;
            if (model_sel !== 1'b0) begin
                miscompares++; $display("FAIL stream_model_sel c=%0d got %b want 0", c, model_sel);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ea;
        logic       ev;
        logic       es;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            instr_ready = !(c >= 4 && c <= 9);
            #2;
            ev = (c >= 2);
            if (c <= 3)       ea = 8'(c - 2);
            else if (c <= 10) ea = 8'h02;
            else              ea = 8'(c - 8);
            es = (c >= 4 && c <= 9);
            vectors++;
            if (instr_valid !== ev) begin
                miscompares++; $display("FAIL bp_valid c=%0d got %b want %b", c, instr_valid, ev);
            end else if (ev && (instr_addr !== ea || instr !== (ea ^ 8'h5A))) begin
                miscompares++;
                $display("FAIL bp_pair c=%0d got %h/%h want %h/%h", c, instr_addr, instr, ea, ea ^ 8'h5A);
            end
            vectors++;
            if (model_sel !== es) begin
                miscompares++; $display("FAIL bp_model_sel c=%0d got %b want %b", c, model_sel, es);
            end
            if (es) begin
                vectors++;
                if (load_value !== 8'h04 || pc !== 8'h04) begin
                    miscompares++;
                    $display("FAIL bp_hold c=%0d load_value=%h pc=%h want 04/04", c, load_value, pc);
                end
            end
            if (c == 6) begin
                vectors++;
                if (dut.count !== 2'd2) begin
                    miscompares++; $display("FAIL bp_count got %0d want 2", dut.count);
                end
            end
            next_cycle();
        end
        instr_ready = 1'b1;
    endtask

    // Branch (or restart+branch) at cycle 5 of a running stream.
    task automatic test_redirect(input logic with_restart);
        logic [7:0] ea;
        logic       ev;
        logic [7:0] base;
        base = with_restart ? 8'h00 : 8'h40;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            branch_req = (c == 5);
            branch_target = (c == 5) ? 8'h40 : 8'h00;
            restart = with_restart && (c == 5);
            #2;
            ev = (c >= 2 && c <= 4) || (c >= 8);
            ea = (c <= 4) ? 8'(c - 2) : base + 8'(c - 8);
            vectors++;
            if (instr_valid !== ev) begin
                miscompares++; $display("FAIL redir_valid r=%b c=%0d got %b want %b", with_restart, c, instr_valid, ev);
            end else if (ev && (instr_addr !== ea || instr !== (ea ^ 8'h5A))) begin
                miscompares++;
                $display("FAIL redir_pair r=%b c=%0d got %h/%h want %h/%h", with_restart, c, instr_addr, instr, ea, ea ^ 8'h5A);
            end
            if (c == 5) begin
                vectors++;
                if (model_sel !== !with_restart || pc_recount !== with_restart) begin
                    miscompares++;
                    $display("FAIL redir_ctrl r=%b model_sel=%b pc_recount=%b want %b/%b", with_restart, model_sel, pc_recount, !with_restart, with_restart);
                end
                if (!with_restart) begin
                    vectors++;
                    if (load_value !== 8'h40) begin
                        miscompares++; $display("FAIL redir_target got %h want 40", load_value);
                    end
                end
            end
            next_cycle();
        end
        branch_req = 1'b0;
        restart = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        logic       ev;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            branch_req = (c == 3);
            branch_target = (c == 3) ? 8'hFE : 8'h00;
            #2;
            ev = (c == 2) || (c >= 6);
            ea = (c == 2) ? 8'h00 : 8'hFE + 8'(c - 6);
            vectors++;
            if (instr_valid !== ev) begin
                miscompares++; $display("FAIL wrap_valid c=%0d got %b want %b", c, instr_valid, ev);
            end else if (ev && (instr_addr !== ea || instr !== (ea ^ 8'h5A))) begin
                miscompares++;
                $display("FAIL wrap_pair c=%0d got %h/%h want %h/%h", c, instr_addr, instr, ea, ea ^ 8'h5A);
            end
            next_cycle();
        end
        branch_req = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [7:0] ea;
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            vectors++;
            if (instr_valid !== (c >= 2)) begin
                miscompares++; $display("FAIL rms_fill_valid c=%0d got %b want %b", c, instr_valid, c >= 2);
            end else if (c >= 2 && instr_addr !== 8'h00) begin
                miscompares++; $display("FAIL rms_fill_addr c=%0d got %h want 00", c, instr_addr);
            end
            if (c == 3) begin
                vectors++;
                if (model_sel !== 1'b1 || dut.count !== 2'd2) begin
                    miscompares++;
                    $display("FAIL rms_full model_sel=%b count=%0d want 1/2", model_sel, dut.count);
                end
            end
            next_cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || dut.count !== 2'd0 || instr_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL rms_async valid=%b count=%0d addr=%h want 0/0/00", instr_valid, dut.count, instr_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            ea = 8'(c - 2);
            vectors++;
            if (instr_valid !== (c >= 2)) begin
                miscompares++; $display("FAIL rms_restart_valid c=%0d got %b want %b", c, instr_valid, c >= 2);
            end else if (c >= 2 && (instr_addr !== ea || instr !== (ea ^ 8'h5A))) begin
                miscompares++;
                $display("FAIL rms_restart_pair c=%0d got %h/%h want %h/%h", c, instr_addr, instr, ea, ea ^ 8'h5A);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_wrap();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch stage directly downstream of the program counter. It turns the counter's address stream and the synchronous RAM's read data into a valid/ready instruction stream for decode, buffered in a 2-entry queue. It steers the counter through `model_sel`/`load_value`/`pc_recount` to stall (hold PC), branch (load target) and restart (PC to 0), because the counter otherwise steps on every clock.

## Interface
Parameters:
- `DW`, 8, instruction word width.
- `AW`, 8, address width; must match the PC.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc_in` in AW: current PC, driven by the counter's `pc_w`; also the RAM read address.
- `mem_rdata` in DW: synchronous RAM output; holds the word for the address presented in the previous cycle.
- `branch_req` in 1: redirect request, one cycle.
- `branch_target` in AW: redirect address.
- `restart` in 1: restart program at address 0.
- `model_sel` out 1: to counter; 1 means load `load_value` on the next edge.
- `load_value` out AW: to counter.
- `pc_recount` out 1: to counter; 1 means PC goes to 0 on the next edge.
- `instr` out DW: queue head instruction.
- `instr_addr` out AW: address of `instr`.
- `instr_valid` out 1: queue head is valid.
- `instr_ready` in 1: decode accepts the head.

## Operation
State:
- 2-entry FIFO of {addr, data}; occupancy `count` 0..2.
- `req_valid_q`/`req_addr_q`: a read was issued last cycle and is not squashed.

Per cycle, in priority order:
1. **restart**
   - `pc_recount`=1, `model_sel`=0.
   - Flush FIFO (`count`←0), `req_valid_q`←0, `instr_valid` forced 0.
2. **branch_req**
   - `model_sel`=1, `load_value`=`branch_target`.
   - Flush FIFO, `req_valid_q`←0, `instr_valid` forced 0.
   - The read of the current `pc_in` is squashed.
3. **Normal**
   - pop = `instr_valid` & `instr_ready`.
   - `count_next` = `count` + `req_valid_q` − pop.
   - If `req_valid_q`, {`req_addr_q`, `mem_rdata`} is written to the FIFO tail at the edge.
   - Accept `pc_in` iff `count_next` ≤ 1:
     - `model_sel`=0 (counter steps).
     - `req_valid_q`←1, `req_addr_q`←`pc_in`.
   - Else stall:
     - `model_sel`=1, `load_value`=`pc_in` (PC held, re-issued next cycle).
     - `req_valid_q`←0.

Rules:
- Outputs `model_sel`/`load_value`/`pc_recount`/`instr_valid` are combinational from state and inputs.
- `load_value`=`pc_in` whenever not branching.
- Pop during a flush cycle is ignored; the consumer sees `instr_valid`=0.
- Address arithmetic belongs to the counter; 0xFF→0x00 wrap needs no special handling here.
- Occupancy never exceeds 2; FIFO write while full is impossible by construction. The bench asserts this.

## Timing
- While `reset` is high:
  - `count`=0, `req_valid_q`=0.
  - `instr_valid`=0, `model_sel`=0, `pc_recount`=0, `load_value`=`pc_in`.
  - `instr`/`instr_addr`=0.
- Latency:
  - Address accepted in cycle n → RAM data in cycle n+1 → written at end of n+1 → `instr_valid` in cycle n+2.
  - First instruction appears 2 cycles after reset release.
- Throughput: 1 instr/cycle with `instr_ready` held 1 (steady `count`=1).
- Redirect penalty:
  - Branch/restart in cycle n → new address fetched in n+1 → first valid instruction in n+3.
  - No stale instruction ever appears.
- Reset mid-operation clears the queue immediately (async); no partial entry survives.

## Test plan
- **Stream.** RAM mem[a]=a^8'h5A, reset release, `instr_ready`=1 → `instr_valid` from cycle 2; pairs (0x00,0x5A), (0x01,0x5B), … with no gaps.
- **Backpressure.** `instr_ready`=0 from cycle 4 for 6 cycles → `count` reaches 2; `model_sel`=1 with `load_value`=`pc_in` (PC frozen); on release, addresses continue consecutively with no loss or duplication.
- **Branch.** `branch_req`=1, target 0x40 mid-stream → `instr_valid`=0 that cycle and the next 2; next instruction is (0x40, 0x1A); no pre-branch address follows.
- **Restart plus branch same cycle.** Both asserted → `pc_recount`=1, `model_sel`=0; next instruction address 0x00.
- **Wrap.** Branch to 0xFE, stream → addresses 0xFE, 0xFF, 0x00, 0x01.
- **Reset mid-stall.** Queue full with `instr_ready`=0, assert `reset` → `instr_valid`=0 immediately; after release, fetch restarts at 0x00 with 2-cycle latency.
